multicycle_ctrl: RTL

Multi-cycle control FSM that sequences the RV32I datapath (PC, IR, register file, immediate generator, ALU, data memory) one instruction at a time. It decodes opcode bits [6:2] from the instruction register and drives the datapath strobes and muxes. It also handles the instruction and data memory handshakes. It detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for an RV32I datapath.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for one instruction at a time,
// decoding opcode bits [6:2] of the IR and driving datapath strobes and muxes.
//
// Ports:
//   clk_i, rst_n_i      clock (rising edge), asynchronous active-low reset
//   instr_data_i        IR contents, stable from DECODE until the next fetch completes
//   imem_ready_i        instruction memory ready / data valid
//   dmem_ready_i        data memory access complete
//   branch_taken_i      ALU branch comparison result, valid in EXEC
//   imem_req_o          instruction fetch request
//   dmem_req_o          data memory request
//   dmem_we_o           data memory write enable (stores)
//   ir_write_o          latch instruction into IR
//   pc_write_o          update PC
//   pc_src_o            0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared
//   alu_src_b_o         0=rs2, 1=immediate
//   reg_write_o         register file write enable
//   wb_sel_o            0=ALU, 1=memory data, 2=PC+4
//   state_o             current state encoding
//   trap_o              controller halted in TRAP
//   trap_cause_o        1=illegal opcode, 0=memory timeout
//   retired_o           retired-instruction count (wraps)
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [31:0]      instr_data_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             branch_taken_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_b_o,
    output logic             reg_write_o,
    output logic [1:0]       wb_sel_o,
    output logic [2:0]       state_o,
    output logic             trap_o,
    output logic             trap_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retired_cnt;
    logic              cause_reg;

    // Opcode decode; legality also requires the 32-bit encoding marker 2'b11.
    logic [4:0] opc;
    logic       is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_legal;

    assign opc       = instr_data_i[6:2];
    assign is_op     = (opc == 5'b01100);
    assign is_op_imm = (opc == 5'b00100);
    assign is_load   = (opc == 5'b00000);
    assign is_store  = (opc == 5'b01000);
    assign is_branch = (opc == 5'b11000);
    assign is_jal    = (opc == 5'b11011);
    assign is_jalr   = (opc == 5'b11001);
    assign is_legal  = (instr_data_i[1:0] == 2'b11) &&
                       (is_op || is_op_imm || is_load || is_store ||
                        is_branch || is_jal || is_jalr);

    // Ready arriving on the limit cycle wins: timeout only fires when ready is low.
    logic mem_wait, timeout_hit;

    assign mem_wait    = ((state == StFetch) && !imem_ready_i) ||
                         ((state == StMem)   && !dmem_ready_i);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait &&
                         (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            retired_cnt <= '0;
            cause_reg   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    state    <= StFetch;
                    wait_cnt <= '0;
                end
                StFetch: begin
                    if (imem_ready_i) begin
                        state <= StDecode;
                    end else if (timeout_hit) begin
                        state     <= StTrap;
                        cause_reg <= 1'b0;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                StDecode: begin
                    if (is_legal) begin
                        state <= StExec;
                    end else begin
                        state     <= StTrap;
                        cause_reg <= 1'b1;
                    end
                end
                StExec: begin
                    if (is_branch) begin
                        state       <= StFetch;
                        wait_cnt    <= '0;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                    end else if (is_load || is_store) begin
                        state    <= StMem;
                        wait_cnt <= '0;
                    end else begin
                        state <= StWb;
                    end
                end
                StMem: begin
                    if (dmem_ready_i) begin
                        if (is_store) begin
                            state       <= StFetch;
                            wait_cnt    <= '0;
                            retired_cnt <= retired_cnt + CNT_W'(1);
                        end else begin
                            state <= StWb;
                        end
                    end else if (timeout_hit) begin
                        state     <= StTrap;
                        cause_reg <= 1'b0;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                StWb: begin
                    state       <= StFetch;
                    wait_cnt    <= '0;
                    retired_cnt <= retired_cnt + CNT_W'(1);
                end
                StTrap: begin
                    state <= StTrap;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 2'd0;
        alu_src_b_o = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = 2'd0;
        trap_o      = 1'b0;
        unique case (state)
            StFetch: begin
                imem_req_o = 1'b1;
                ir_write_o = imem_ready_i;
            end
            StExec: begin
                alu_src_b_o = !(is_op || is_branch);
                if (is_branch) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = branch_taken_i ? 2'd1 : 2'd0;
                end
            end
            StMem: begin
                alu_src_b_o = 1'b1;
                dmem_req_o  = 1'b1;
                dmem_we_o   = is_store;
                pc_write_o  = dmem_ready_i && is_store;
            end
            StWb: begin
                alu_src_b_o = !(is_op || is_branch);
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
                wb_sel_o    = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                pc_src_o    = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
            end
            StTrap: begin
                trap_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o      = state;
    assign trap_cause_o = cause_reg;
    assign retired_o    = retired_cnt;

endmodule
